// File: rtl/text_ctrl_pkg.sv
// text_ctrl_pkg: character codes, printable range and FSM states for the text write controller
package text_ctrl_pkg;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] PRINT_MIN  = 8'h20;
    localparam logic [7:0] PRINT_MAX  = 8'h7E;

    typedef enum logic [1:0] {IDLE, CLEAR_SCREEN, CLEAR_LINE} state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return c >= PRINT_MIN && c <= PRINT_MAX;
    endfunction
endpackage

// File: rtl/uart_byte_buffer.sv
// uart_byte_buffer: rise detect on the UART strobe, one-deep pending byte, pop handshake, overflow pulse
module uart_byte_buffer (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] uart_data,
    input  logic       uart_data_ready,
    input  logic       take,
    output logic       avail,
    output logic [7:0] rx_char,
    output logic       overflow
);
    logic       ready_q;
    logic       pend_v;
    logic [7:0] pend_d;
    logic       rise;

    assign rise    = uart_data_ready & ~ready_q;
    assign avail   = pend_v | rise;
    assign rx_char = pend_v ? pend_d : uart_data;

    // Pending byte is served before a fresh edge; an edge that finds it full is dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            ready_q  <= 1'b0;
            pend_v   <= 1'b0;
            pend_d   <= '0;
            overflow <= 1'b0;
        end else begin
            ready_q  <= uart_data_ready;
            overflow <= rise & pend_v;
            if (pend_v) pend_v <= ~take;
            else if (rise & ~take) begin
                pend_v <= 1'b1;
                pend_d <= uart_data;
            end
        end
    end
endmodule

// File: rtl/text_write_controller.sv
// text_write_controller: writes UART bytes into VGA text memory with cursor tracking and clears
module text_write_controller
    import text_ctrl_pkg::*;
#(
    parameter int COLS           = 80,
    parameter int ROWS           = 30,
    parameter int ADDR_W         = 13,
    parameter int DATA_W         = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              uart_data,
    input  logic                    uart_data_ready,
    output logic [DATA_W-1:0]       mem_data,
    output logic [ADDR_W-1:0]       mem_address,
    output logic                    mem_write,
    output logic                    busy,
    output logic [$clog2(COLS)-1:0] cursor_col,
    output logic [$clog2(ROWS)-1:0] cursor_row,
    output logic                    overflow
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [ADDR_W-1:0] SCREEN_LAST = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LINE_LAST   = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(COLS);
    localparam logic [CW-1:0]     COL_LAST    = CW'(COLS - 1);
    localparam logic [RW-1:0]     ROW_LAST    = RW'(ROWS - 1);
    localparam logic [DATA_W-1:0] SPACE       = DATA_W'(CHAR_SPACE);

    state_t              state, state_n;
    logic [CW-1:0]       col_n;
    logic [RW-1:0]       row_n;
    logic [ADDR_W-1:0]   line_base, base_n, clr_addr, clr_n, cnt, cnt_n, addr_n;
    logic [DATA_W-1:0]   data_n;
    logic                wr_n, busy_n, take, advance, avail;
    logic [7:0]          rx_char;

    uart_byte_buffer u_buf (
        .clock           (clock),
        .reset           (reset),
        .uart_data       (uart_data),
        .uart_data_ready (uart_data_ready),
        .take            (take),
        .avail           (avail),
        .rx_char         (rx_char),
        .overflow        (overflow)
    );

    // Next-state and write decode: clears sweep an address counter, IDLE decodes one byte per cycle
    always_comb begin
        state_n = state;
        col_n   = cursor_col;
        row_n   = cursor_row;
        base_n  = line_base;
        clr_n   = clr_addr;
        cnt_n   = cnt;
        wr_n    = 1'b0;
        data_n  = mem_data;
        addr_n  = mem_address;
        busy_n  = 1'b0;
        take    = 1'b0;
        advance = 1'b0;
        if (state != IDLE) begin
            wr_n   = 1'b1;
            busy_n = 1'b1;
            data_n = SPACE;
            addr_n = clr_addr;
            clr_n  = clr_addr + ADDR_W'(1);
            cnt_n  = cnt + ADDR_W'(1);
            if (cnt == (state == CLEAR_SCREEN ? SCREEN_LAST : LINE_LAST)) state_n = IDLE;
        end else if (avail) begin
            take = 1'b1;
            if (is_printable(rx_char)) begin
                wr_n    = 1'b1;
                data_n  = DATA_W'(rx_char);
                addr_n  = line_base + ADDR_W'(cursor_col);
                advance = cursor_col == COL_LAST;
                col_n   = advance ? '0 : cursor_col + CW'(1);
            end else if (rx_char == CHAR_CR) begin
                col_n = '0;
            end else if (rx_char == CHAR_LF) begin
                advance = 1'b1;
            end else if (rx_char == CHAR_BS && cursor_col != '0) begin
                wr_n   = 1'b1;
                data_n = SPACE;
                col_n  = cursor_col - CW'(1);
                addr_n = line_base + ADDR_W'(cursor_col - CW'(1));
            end else if (rx_char == CHAR_FF) begin
                col_n   = '0;
                row_n   = '0;
                base_n  = '0;
                clr_n   = '0;
                cnt_n   = '0;
                state_n = CLEAR_SCREEN;
            end
        end
        if (advance) begin
            row_n   = cursor_row == ROW_LAST ? '0 : cursor_row + RW'(1);
            base_n  = cursor_row == ROW_LAST ? '0 : line_base + COLS_A;
            clr_n   = base_n;
            cnt_n   = '0;
            state_n = CLEAR_LINE;
        end
    end

    // State, cursor and registered memory-port outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= CLEAR_ON_RESET != 0 ? CLEAR_SCREEN : IDLE;
            cursor_col  <= '0;
            cursor_row  <= '0;
            line_base   <= '0;
            clr_addr    <= '0;
            cnt         <= '0;
            mem_write   <= 1'b0;
            mem_data    <= '0;
            mem_address <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cursor_col  <= col_n;
            cursor_row  <= row_n;
            line_base   <= base_n;
            clr_addr    <= clr_n;
            cnt         <= cnt_n;
            mem_write   <= wr_n;
            mem_data    <= data_n;
            mem_address <= addr_n;
            busy        <= busy_n;
        end
    end
endmodule

// File: tb/tb_text_write_controller.sv
// tb_text_write_controller: vector table, multi-cycle corner sequences and a random run against a screen model
module tb_text_write_controller;
    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  uart_data = 8'h00;
    logic        uart_data_ready = 1'b0;
    logic [7:0]  mem_data;
    logic [12:0] mem_address;
    logic        mem_write, busy, overflow;
    logic [1:0]  cursor_col, cursor_row;

    text_write_controller #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(13), .DATA_W(8), .CLEAR_ON_RESET(1)) dut (
        .clock           (clk),
        .reset           (reset),
        .uart_data       (uart_data),
        .uart_data_ready (uart_data_ready),
        .mem_data        (mem_data),
        .mem_address     (mem_address),
        .mem_write       (mem_write),
        .busy            (busy),
        .cursor_col      (cursor_col),
        .cursor_row      (cursor_row),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int wa[$];
    int wd[$];
    logic [7:0] shadow[CELLS];
    logic [7:0] mscr[CELLS];
    int mc, mr;
    int ovf_cnt = 0;
    int oob = 0;

    typedef struct {
        logic [7:0] b;
        int hold, nw, fa, fd, la, ld, col, row;
    } vec_t;
    vec_t tbl[17];

    // Write log and shadow screen collected away from the active edge
    always @(negedge clk) begin
        if (mem_write) begin
            wa.push_back(int'(mem_address));
            wd.push_back(int'(mem_data));
            if (mem_address < 13'(CELLS)) shadow[mem_address] = mem_data;
            else oob++;
        end
        if (overflow) ovf_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int hold, input int settle);
        uart_data = b;
        uart_data_ready = 1'b1;
        repeat (hold) @(negedge clk);
        uart_data_ready = 1'b0;
        repeat (settle) @(negedge clk);
    endtask

    task automatic reset_and_check_clear();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_write", int'(mem_write), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_addr", int'(mem_address), 0);
        chk("rst_cursor", int'({cursor_row, cursor_col}), 0);
        chk("rst_ovf", int'(overflow), 0);
        reset = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            @(negedge clk);
            chk("clr_write", int'(mem_write), 1);
            chk("clr_addr", int'(mem_address), i);
            chk("clr_data", int'(mem_data), 32'h20);
            chk("clr_busy", int'(busy), 1);
        end
        @(negedge clk);
        chk("clr_end_write", int'(mem_write), 0);
        chk("clr_end_busy", int'(busy), 0);
        chk("clr_cursor", int'({cursor_row, cursor_col}), 0);
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit adv = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            mscr[mr * COLS + mc] = b;
            if (mc == COLS - 1) begin
                mc = 0;
                adv = 1;
            end else mc++;
        end else if (b == 8'h0D) mc = 0;
        else if (b == 8'h0A) adv = 1;
        else if (b == 8'h08) begin
            if (mc > 0) begin
                mc--;
                mscr[mr * COLS + mc] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            mc = 0;
            mr = 0;
            for (int k = 0; k < CELLS; k++) mscr[k] = 8'h20;
        end
        if (adv) begin
            mr = (mr + 1) % ROWS;
            for (int k = 0; k < COLS; k++) mscr[mr * COLS + k] = 8'h20;
        end
    endtask

    initial begin
        int start, ovf0, n0;
        logic [7:0] b;
        tbl[0]  = '{8'hAC, 20, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{8'h41, 20, 1, 0, 8'h41, 0, 8'h41, 1, 0};
        tbl[2]  = '{8'h42, 1, 1, 1, 8'h42, 1, 8'h42, 2, 0};
        tbl[3]  = '{8'h43, 1, 1, 2, 8'h43, 2, 8'h43, 3, 0};
        tbl[4]  = '{8'h44, 1, 5, 3, 8'h44, 7, 8'h20, 0, 1};
        tbl[5]  = '{8'h0A, 1, 4, 8, 8'h20, 11, 8'h20, 0, 2};
        tbl[6]  = '{8'h0A, 1, 4, 0, 8'h20, 3, 8'h20, 0, 0};
        tbl[7]  = '{8'h58, 1, 1, 0, 8'h58, 0, 8'h58, 1, 0};
        tbl[8]  = '{8'h59, 1, 1, 1, 8'h59, 1, 8'h59, 2, 0};
        tbl[9]  = '{8'h5A, 1, 1, 2, 8'h5A, 2, 8'h5A, 3, 0};
        tbl[10] = '{8'h0D, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{8'h58, 1, 1, 0, 8'h58, 0, 8'h58, 1, 0};
        tbl[12] = '{8'h08, 1, 1, 0, 8'h20, 0, 8'h20, 0, 0};
        tbl[13] = '{8'h08, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{8'h7F, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[15] = '{8'h7E, 1, 1, 0, 8'h7E, 0, 8'h7E, 1, 0};
        tbl[16] = '{8'h1F, 3, 0, 0, 0, 0, 0, 1, 0};

        @(negedge clk);
        reset_and_check_clear();

        for (int i = 0; i < 17; i++) begin
            start = wa.size();
            send(tbl[i].b, tbl[i].hold, 16);
            chk($sformatf("vec%0d_nwrites", i), wa.size() - start, tbl[i].nw);
            if (tbl[i].nw > 0 && wa.size() > start) begin
                chk($sformatf("vec%0d_first_addr", i), wa[start], tbl[i].fa);
                chk($sformatf("vec%0d_first_data", i), wd[start], tbl[i].fd);
                chk($sformatf("vec%0d_last_addr", i), wa[wa.size() - 1], tbl[i].la);
                chk($sformatf("vec%0d_last_data", i), wd[wd.size() - 1], tbl[i].ld);
            end
            chk($sformatf("vec%0d_col", i), int'(cursor_col), tbl[i].col);
            chk($sformatf("vec%0d_row", i), int'(cursor_row), tbl[i].row);
        end

        uart_data = 8'h4B;
        uart_data_ready = 1'b1;
        @(negedge clk);
        chk("lat_write", int'(mem_write), 1);
        chk("lat_addr", int'(mem_address), 1);
        chk("lat_data", int'(mem_data), 32'h4B);
        chk("lat_col", int'(cursor_col), 2);
        uart_data_ready = 1'b0;
        @(negedge clk);
        chk("lat_single", int'(mem_write), 0);
        repeat (3) @(negedge clk);

        start = wa.size();
        ovf0 = ovf_cnt;
        send(8'h0C, 1, 1);
        send(8'h50, 1, 1);
        send(8'h51, 1, 20);
        chk("ff_ovf_pulses", ovf_cnt - ovf0, 1);
        chk("ff_nwrites", wa.size() - start, CELLS + 1);
        if (wa.size() > 0) begin
            chk("ff_buf_addr", wa[wa.size() - 1], 0);
            chk("ff_buf_data", wd[wd.size() - 1], 32'h50);
        end
        chk("ff_cursor_col", int'(cursor_col), 1);
        chk("ff_cursor_row", int'(cursor_row), 0);

        send(8'h0C, 1, 5);
        reset_and_check_clear();

        mc = 0;
        mr = 0;
        for (int k = 0; k < CELLS; k++) mscr[k] = 8'h20;
        ovf0 = ovf_cnt;
        for (int i = 0; i < 200; i++) begin
            n0 = $urandom_range(0, 11);
            b = n0 < 6 ? 8'($urandom_range(32'h20, 32'h7E)) :
                n0 == 6 ? 8'h0D : n0 == 7 ? 8'h0A : n0 == 8 ? 8'h08 :
                n0 == 9 ? 8'h0C : 8'($urandom_range(0, 255));
            send(b, $urandom_range(1, 4), 16);
            model_byte(b);
            chk($sformatf("rnd%0d_col b=%0h", i, b), int'(cursor_col), mc);
            chk($sformatf("rnd%0d_row b=%0h", i, b), int'(cursor_row), mr);
        end
        for (int k = 0; k < CELLS; k++) chk($sformatf("rnd_cell%0d", k), int'(shadow[k]), int'(mscr[k]));
        chk("rnd_no_overflow", ovf_cnt - ovf0, 0);
        chk("addr_in_range", oob, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
